// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin shared LED blinker with ON/OFF/GAP phases timed in prescaler ticks.
// Optional abort input enabled by LED_BLINK_ARB_ABORT_EN.
module led_blink_arbiter #(
  parameter int N_REQ     = 2,
  parameter int CNT_MAX   = 24,
  parameter int BLINK_W   = 4,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
`ifdef LED_BLINK_ARB_ABORT_EN
  input  logic                       abort,
`endif
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*BLINK_W-1:0]   req_count,
  output logic [N_REQ-1:0]           req_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       done,
  output logic                       led_out
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int KW   = ID_W + 1;
  localparam int CW   = $clog2(CNT_MAX + 1);
  localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                                               : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W = $clog2(MAXT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t             r_state, w_nxt;
  logic [CW-1:0]      r_cnt;
  logic [PH_W-1:0]    r_phase, w_lim;
  logic [BLINK_W-1:0] r_rem, w_cnt_in;
  logic [ID_W-1:0]    r_ptr, r_gid, w_sel, w_nptr;
  logic [KW-1:0]      w_k;
  logic               r_done, w_tick, w_end, w_accept, w_abort;

`ifdef LED_BLINK_ARB_ABORT_EN
  assign w_abort = abort && r_state != S_IDLE;
`else
  assign w_abort = 1'b0;
`endif

  // Lowest rotated offset from the pointer wins, hence the downward scan.
  always_comb begin
    w_sel = '0;
    w_k = '0;
    w_cnt_in = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_k = {1'b0, r_ptr} + KW'(i);
      w_k = (w_k >= KW'(N_REQ)) ? w_k - KW'(N_REQ) : w_k;
      if (req_valid[w_k[ID_W-1:0]]) w_sel = w_k[ID_W-1:0];
    end
    for (int i = 0; i < N_REQ; i++)
      if (w_sel == ID_W'(i)) w_cnt_in = req_count[i*BLINK_W +: BLINK_W];
  end

  assign w_accept  = r_state == S_IDLE && |req_valid;
  assign w_nptr    = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign req_ready = w_accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign w_tick    = r_cnt == CW'(CNT_MAX);
  assign w_lim     = (r_state == S_ON) ? PH_W'(ON_TICKS - 1) :
                     (r_state == S_OFF) ? PH_W'(OFF_TICKS - 1) : PH_W'(GAP_TICKS - 1);
  assign w_end     = w_tick && r_phase == w_lim;

  always_comb begin
    w_nxt = r_state;
    if (w_abort) w_nxt = S_IDLE;
    else if (r_state == S_IDLE) w_nxt = (w_accept && w_cnt_in != '0) ? S_ON : S_IDLE;
    else if (w_end) w_nxt = (r_state == S_ON) ? S_OFF :
                            (r_state == S_OFF) ? ((r_rem != '0) ? S_ON : S_GAP) : S_IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else r_state <= w_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt   <= '0;
      r_phase <= '0;
      r_rem   <= '0;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_cnt   <= (r_state == S_IDLE || w_nxt == S_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      r_phase <= (r_state == S_IDLE || w_end || w_abort) ? '0 : r_phase + PH_W'(w_tick);
      r_done  <= (w_accept && w_cnt_in == '0) || (r_state == S_GAP && w_end) || w_abort;
      if (w_accept) begin
        r_rem <= w_cnt_in;
        r_ptr <= w_nptr;
        r_gid <= w_sel;
      end else if (r_state == S_ON && w_end) r_rem <= r_rem - 1'b1;
    end
  end

  assign grant_id = r_gid;
  assign busy     = r_state != S_IDLE;
  assign done     = r_done;
  assign led_out  = r_state == S_ON;
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: directed stimulus with a cycle-accurate scoreboard model of led_blink_arbiter.
module tb_led_blink_arbiter;
  localparam int N = 2, CM = 24, BW = 4, ONT = 2, OFFT = 2, GT = 4;
  localparam int TCK = CM + 1, ONC = ONT * TCK, BLK = (ONT + OFFT) * TCK, GAPC = GT * TCK;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*BW-1:0] req_count = '0;
  logic [N-1:0]  req_ready;
  logic [0:0]    grant_id;
  logic          busy, done, led_out;
`ifdef LED_BLINK_ARB_ABORT_EN
  logic          abort = 1'b0;
`endif

  led_blink_arbiter #(.N_REQ(N), .CNT_MAX(CM), .BLINK_W(BW), .ON_TICKS(ONT), .OFF_TICKS(OFFT),
                      .GAP_TICKS(GT)) dut (
    .sys_clk(clk), .sys_rst(rst),
`ifdef LED_BLINK_ARB_ABORT_EN
    .abort(abort),
`endif
    .req_valid(req_valid), .req_count(req_count), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .done(done), .led_out(led_out));

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, failures = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int cyc;} exp_t;
  exp_t q[$];
  int m_ptr = 0, m_gid = 0, m_acc = 0, m_k = 0, m_idle = 0, sel, k, off;
  bit m_active = 1'b0, exp_busy, exp_led, idle;
  logic [N-1:0] exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: derives every output from the accept history, checked each cycle.
  always @(negedge clk) if (mon_en) begin
    idle = cyc >= m_idle;
    sel = -1;
    exp_rdy = '0;
    if (idle) for (int j = N - 1; j >= 0; j--) if (req_valid[(m_ptr + j) % N]) sel = (m_ptr + j) % N;
    if (sel >= 0) exp_rdy[sel] = 1'b1;
    off = cyc - m_acc - 1;
    exp_busy = m_active && off >= 0 && off < m_k * BLK + GAPC;
    exp_led = m_active && off >= 0 && off < m_k * BLK && (off % BLK) < ONC;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("led_out", 32'(led_out), 32'(exp_led));
    chk("grant_id", 32'(grant_id), m_gid);
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("done", 32'(done), 1);
      chk("done_grant", 32'(grant_id), q[0].id);
      void'(q.pop_front());
    end else chk("done", 32'(done), 0);
`ifdef LED_BLINK_ARB_ABORT_EN
    if (abort && exp_busy && !rst) begin
      q.delete();
      q.push_back('{m_gid, cyc + 1});
      m_active = 1'b0;
      m_idle = cyc + 1;
    end
`endif
    if (sel >= 0 && !rst) begin
      k = int'(req_count[sel*BW +: BW]);
      m_gid = sel;
      m_ptr = (sel + 1) % N;
      m_active = k != 0;
      m_acc = cyc;
      m_k = k;
      m_idle = (k == 0) ? cyc + 1 : cyc + k * BLK + GAPC + 1;
      q.push_back('{sel, m_idle});
    end
    if (rst) begin
      m_ptr = 0; m_gid = 0; m_active = 1'b0; m_idle = cyc + 1;
      q.delete();
    end
  end

  task automatic send(input int id, input int cnt, output int ta);
    req_count[id*BW +: BW] = BW'(cnt);
    req_valid[id] = 1'b1;
    ta = -1;
    for (int i = 0; i < 5000 && ta < 0; i++) begin
      @(negedge clk);
      if (req_ready[id]) ta = cyc;
    end
    if (ta < 0) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 3000);
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int t, n;
    int a[4];
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_led", 32'(led_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    rst = 1'b0;
    // three blinks from requester 0
    send(0, 3, t);
    @(negedge clk); chk("t1_led_first", 32'(led_out), 1);
    repeat (49) @(negedge clk);
    chk("t1_led_last_on", 32'(led_out), 1);
    @(negedge clk); chk("t1_led_off", 32'(led_out), 0);
    wait_idle();
    chk("t1_done_cycle", cyc, t + 401);
    chk("t1_done", 32'(done), 1);
    @(posedge clk); #1;
    // zero-count request completes immediately and moves the pointer back to 0
    send(1, 0, t);
    @(negedge clk);
    chk("t3_done", 32'(done), 1);
    chk("t3_led", 32'(led_out), 0);
    chk("t3_busy", 32'(busy), 0);
    @(posedge clk); #1;
    // both requesters held valid: grants must alternate
    req_count = {4'd2, 4'd1};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while ((req_ready & req_valid) == 0 && n < 1000);
      chk("t2_grant", 32'(req_ready), (g % 2) ? 2 : 1);
      a[g] = cyc;
      @(posedge clk); #1;
      if (g == 3) req_valid = '0;
    end
    chk("t2_span0", a[1] - a[0], 201);
    chk("t2_span1", a[2] - a[1], 301);
    wait_idle();
    @(posedge clk); #1;
    // reset mid-burst
    send(0, 5, t);
    repeat (119) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_cycle", cyc, t + 121);
    chk("t4_led", 32'(led_out), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ready", 32'(req_ready), 0);
    chk("t4_done", 32'(done), 0);
    @(posedge clk); #1;
    req_count = {4'd1, 4'd1};
    req_valid = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 100);
    chk("t4_grant_after_rst", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    @(posedge clk); #1;
    // maximum blink count
    send(1, 15, t);
    wait_idle();
    chk("t5_done_cycle", cyc, t + 1601);
    chk("t5_done", 32'(done), 1);
    @(posedge clk); #1;
`ifdef LED_BLINK_ARB_ABORT_EN
    send(0, 4, t);
    repeat (29) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("ab_led", 32'(led_out), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 1);
    @(posedge clk); #1;
    send(1, 1, t);
    @(negedge clk); chk("ab_restart_led", 32'(led_out), 1);
    wait_idle();
    chk("ab_restart_done", cyc, t + 201);
    @(posedge clk); #1;
`endif
    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
